// File: rtl/riscv_chk_pkg.sv
// riscv_chk_pkg
//   Shared definitions for the RISC-V checkpoint monitor: the run-control
//   state encoding and the FAIL_CAUSE codes reported on failure.
package riscv_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PASSED = 2'd2,
        ST_FAILED = 2'd3
    } chk_state_e;

    localparam logic [2:0] CAUSE_NONE       = 3'd0;
    localparam logic [2:0] CAUSE_MISMATCH   = 3'd1;
    localparam logic [2:0] CAUSE_SKIPPED    = 3'd2;
    localparam logic [2:0] CAUSE_INCOMPLETE = 3'd3;
    localparam logic [2:0] CAUSE_TIMEOUT    = 3'd4;

endpackage

// File: rtl/riscv_chk_table.sv
// riscv_chk_table
//   Checkpoint table storage: NUM_CHK entries of {inst, ans, mask}.
//   One synchronous write port and one asynchronous read port.
//   Asynchronous reset clears every entry to zero.
// Ports
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_we, i_widx              write enable and entry index
//   i_winst, i_wans, i_wmask  entry contents to write
//   i_ridx                    read index
//   o_rinst, o_rans, o_rmask  entry contents at i_ridx (combinational)
module riscv_chk_table #(
    parameter int NUM_CHK = 64,
    parameter int IDX_W   = 6,
    parameter int CWIDTH  = 32,
    parameter int DWIDTH  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_widx,
    input  logic [CWIDTH-1:0] i_winst,
    input  logic [DWIDTH-1:0] i_wans,
    input  logic [DWIDTH-1:0] i_wmask,
    input  logic [IDX_W-1:0]  i_ridx,
    output logic [CWIDTH-1:0] o_rinst,
    output logic [DWIDTH-1:0] o_rans,
    output logic [DWIDTH-1:0] o_rmask
);

    logic [CWIDTH-1:0] r_inst [NUM_CHK];
    logic [DWIDTH-1:0] r_ans  [NUM_CHK];
    logic [DWIDTH-1:0] r_mask [NUM_CHK];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_CHK; i++) begin
                r_inst[i] <= '0;
                r_ans[i]  <= '0;
                r_mask[i] <= '0;
            end
        end else if (i_we && (int'(i_widx) < NUM_CHK)) begin
            r_inst[i_widx] <= i_winst;
            r_ans[i_widx]  <= i_wans;
            r_mask[i_widx] <= i_wmask;
        end
    end

    // Indices past the table (non power-of-two depth) read as zero.
    always_comb begin
        o_rinst = '0;
        o_rans  = '0;
        o_rmask = '0;
        if (int'(i_ridx) < NUM_CHK) begin
            o_rinst = r_inst[i_ridx];
            o_rans  = r_ans[i_ridx];
            o_rmask = r_mask[i_ridx];
        end
    end

endmodule

// File: rtl/riscv_checkpoint_monitor.sv
// riscv_checkpoint_monitor
//   Watches a RISC-V core's retired-instruction count and debug output and
//   checks them against a table of checkpoints (instruction count, expected
//   value, compare mask) in strictly increasing instruction-count order.
//   Reports pass when the core halts with every checkpoint matched, or fail
//   with a cause, the failing entry index and the observed value.
// Ports
//   CLK, RST                         clock, asynchronous active-high reset
//   CFG_WE/IDX/INST/ANS/MASK         table write (ignored while running)
//   CFG_NUM                          valid entry count, sampled on START
//   START                            one-cycle request to begin a run; it is
//                                    accepted whenever BUSY is low and has no
//                                    effect while BUSY is high
//   NUM_INST, OUTPUT_PORT, HALT      core observation inputs
//   BUSY, DONE, PASS, FAIL           run status
//   FAIL_CAUSE, FAIL_IDX, FAIL_VAL   failure details, held until next START
//   PASS_CNT, CYCLE_CNT              checkpoints passed, cycles spent running
//   DBG_STATE                        raw controller state
module riscv_checkpoint_monitor
    import riscv_chk_pkg::*;
#(
    parameter int NUM_CHK = 64,
    parameter int DWIDTH  = 32,
    parameter int CWIDTH  = 32,
    parameter int TIMEOUT = 1000000,
    localparam int IDX_W  = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CFG_WE,
    input  logic [IDX_W-1:0]  CFG_IDX,
    input  logic [CWIDTH-1:0] CFG_INST,
    input  logic [DWIDTH-1:0] CFG_ANS,
    input  logic [DWIDTH-1:0] CFG_MASK,
    input  logic [IDX_W:0]    CFG_NUM,
    input  logic              START,
    input  logic [CWIDTH-1:0] NUM_INST,
    input  logic [DWIDTH-1:0] OUTPUT_PORT,
    input  logic              HALT,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic              FAIL,
    output logic [2:0]        FAIL_CAUSE,
    output logic [IDX_W-1:0]  FAIL_IDX,
    output logic [DWIDTH-1:0] FAIL_VAL,
    output logic [IDX_W:0]    PASS_CNT,
    output logic [CWIDTH-1:0] CYCLE_CNT,
    output logic [1:0]        DBG_STATE
);

    localparam logic [IDX_W:0]    NUM_MAX = (IDX_W+1)'(NUM_CHK);
    localparam logic [CWIDTH-1:0] TO_LIM  = CWIDTH'(TIMEOUT - 1);

    chk_state_e        r_state, w_state_nxt;
    // r_ptr doubles as the passed-entry count: entries pass strictly in order.
    logic [IDX_W:0]    r_ptr, w_ptr_nxt;
    logic [IDX_W:0]    r_num, w_num_nxt;
    logic [CWIDTH-1:0] r_cycle_cnt, w_cnt_nxt;
    logic [2:0]        r_fail_cause, w_cause_nxt;
    logic [IDX_W-1:0]  r_fail_idx, w_fidx_nxt;
    logic [DWIDTH-1:0] r_fail_val, w_fval_nxt;

    logic              w_tbl_we;
    logic [CWIDTH-1:0] w_rinst;
    logic [DWIDTH-1:0] w_rans;
    logic [DWIDTH-1:0] w_rmask;

    logic              w_active, w_inst_eq, w_masked_eq;
    logic              w_hit, w_mismatch, w_skip;
    logic [IDX_W:0]    w_ptr_chk;
    logic [CWIDTH-1:0] w_cnt_inc;
    logic [IDX_W:0]    w_num_clamped;

    assign w_tbl_we = CFG_WE && (r_state != ST_RUN) && (int'(CFG_IDX) < NUM_CHK);

    riscv_chk_table #(
        .NUM_CHK (NUM_CHK),
        .IDX_W   (IDX_W),
        .CWIDTH  (CWIDTH),
        .DWIDTH  (DWIDTH)
    ) u_table (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_we    (w_tbl_we),
        .i_widx  (CFG_IDX),
        .i_winst (CFG_INST),
        .i_wans  (CFG_ANS),
        .i_wmask (CFG_MASK),
        .i_ridx  (r_ptr[IDX_W-1:0]),
        .o_rinst (w_rinst),
        .o_rans  (w_rans),
        .o_rmask (w_rmask)
    );

    // Checkpoint comparison against the entry under the pointer.
    assign w_active    = (r_ptr < r_num);
    assign w_inst_eq   = (NUM_INST == w_rinst);
    assign w_masked_eq = (((OUTPUT_PORT ^ w_rans) & w_rmask) == '0);
    assign w_hit       = w_active && w_inst_eq && w_masked_eq;
    assign w_mismatch  = w_active && w_inst_eq && !w_masked_eq;
    assign w_skip      = w_active && (NUM_INST > w_rinst);

    // Pointer after this cycle's check; HALT and timeout judge against this.
    assign w_ptr_chk     = w_hit ? (r_ptr + (IDX_W+1)'(1)) : r_ptr;
    assign w_cnt_inc     = (&r_cycle_cnt) ? r_cycle_cnt : (r_cycle_cnt + CWIDTH'(1));
    assign w_num_clamped = (CFG_NUM > NUM_MAX) ? NUM_MAX : CFG_NUM;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_num        <= '0;
            r_cycle_cnt  <= '0;
            r_fail_cause <= CAUSE_NONE;
            r_fail_idx   <= '0;
            r_fail_val   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_num        <= w_num_nxt;
            r_cycle_cnt  <= w_cnt_nxt;
            r_fail_cause <= w_cause_nxt;
            r_fail_idx   <= w_fidx_nxt;
            r_fail_val   <= w_fval_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_num_nxt   = r_num;
        w_cnt_nxt   = r_cycle_cnt;
        w_cause_nxt = r_fail_cause;
        w_fidx_nxt  = r_fail_idx;
        w_fval_nxt  = r_fail_val;

        case (r_state)
            ST_RUN: begin
                w_cnt_nxt = w_cnt_inc;
                w_ptr_nxt = w_ptr_chk;
                // Priority: mismatch/skip, then HALT, then timeout.
                if (w_mismatch || w_skip) begin
                    w_state_nxt = ST_FAILED;
                    w_cause_nxt = w_mismatch ? CAUSE_MISMATCH : CAUSE_SKIPPED;
                    w_fidx_nxt  = r_ptr[IDX_W-1:0];
                    w_fval_nxt  = OUTPUT_PORT;
                end else if (HALT) begin
                    if (w_ptr_chk == r_num) begin
                        w_state_nxt = ST_PASSED;
                    end else begin
                        w_state_nxt = ST_FAILED;
                        w_cause_nxt = CAUSE_INCOMPLETE;
                        w_fidx_nxt  = w_ptr_chk[IDX_W-1:0];
                        w_fval_nxt  = OUTPUT_PORT;
                    end
                end else if (w_cnt_inc >= TO_LIM) begin
                    w_state_nxt = ST_FAILED;
                    w_cause_nxt = CAUSE_TIMEOUT;
                    w_fidx_nxt  = w_ptr_chk[IDX_W-1:0];
                    w_fval_nxt  = OUTPUT_PORT;
                end
            end
            default: begin
                // IDLE, PASSED, FAILED: results held until the next START.
                if (START) begin
                    w_state_nxt = ST_RUN;
                    w_num_nxt   = w_num_clamped;
                    w_ptr_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_cause_nxt = CAUSE_NONE;
                    w_fidx_nxt  = '0;
                    w_fval_nxt  = '0;
                end
            end
        endcase
    end

    assign BUSY       = (r_state == ST_RUN);
    assign PASS       = (r_state == ST_PASSED);
    assign FAIL       = (r_state == ST_FAILED);
    assign DONE       = PASS || FAIL;
    assign FAIL_CAUSE = r_fail_cause;
    assign FAIL_IDX   = r_fail_idx;
    assign FAIL_VAL   = r_fail_val;
    assign PASS_CNT   = r_ptr;
    assign CYCLE_CNT  = r_cycle_cnt;
    assign DBG_STATE  = r_state;

endmodule
